cpu_axi_bridge: RTL

Downstream neighbour of the CPU core. It converts the core's two sram-like ports, instruction and data, into a single AXI3 master toward the memory system. The ports use a req/addr_ok/data_ok handshake. An arbiter grants one port at a time, with data taking priority over instruction. Exactly one AXI transaction is outstanding at any time, so ordering is trivially preserved and read-after-write hazards cannot occur.

---
 rtl/cpu_axi_bridge_if.sv | 93 +++++++++
 rtl/cpu_axi_bridge.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_axi_bridge_if.sv
// rtl/cpu_axi_bridge_if.sv - bundle of the core's sram-like ports and the AXI3 master bus
//
// Purpose: groups every handshake/bus signal of cpu_axi_bridge so the bridge
//   and its environment connect through one port.
// Modports:
//   master - the bridge: answers the inst/data sram ports, drives AXI requests
//   slave  - the environment: the core's sram ports plus the AXI memory slave
interface cpu_axi_bridge_if;
  // instruction sram-like port
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  // data sram-like port
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  // AXI read address / read data
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // AXI write address / write data / write response
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_rdata, inst_addr_ok, inst_data_ok,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_rdata, inst_addr_ok, inst_data_ok,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/cpu_axi_bridge.sv
// rtl/cpu_axi_bridge.sv - arbitrates the core's inst/data sram ports onto one AXI3 master
//
// Purpose: one transaction in flight at a time; data port wins over inst port.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset
//   bus   - cpu_axi_bridge_if.master: inst/data sram-like ports and AXI3 master
// Parameters:
//   INST_ID / DATA_ID - AXI id placed on arid/awid/wid for each port's transactions
module cpu_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic              clk,
  input  logic              reset,
  cpu_axi_bridge_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_ADDR = 3'd3,
    S_WR_RESP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;      // 1 = data port owns the transaction
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  // Grant selection: data port has priority whenever both request.
  logic        grant_any;
  logic        grant_data;
  logic        sel_wr;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  assign grant_any  = bus.data_req | bus.inst_req;
  assign grant_data = bus.data_req;
  assign sel_wr     = grant_data ? bus.data_wr    : bus.inst_wr;
  assign sel_size   = grant_data ? bus.data_size  : bus.inst_size;
  assign sel_addr   = grant_data ? bus.data_addr  : bus.inst_addr;
  assign sel_wdata  = grant_data ? bus.data_wdata : bus.inst_wdata;

  // Write address and write data channels complete independently.
  logic aw_fire;
  logic w_fire;
  assign aw_fire = (state_q == S_WR_ADDR) && !aw_done_q && bus.awready;
  assign w_fire  = (state_q == S_WR_ADDR) && !w_done_q  && bus.wready;

  // State and latched-request register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          owner_d   = grant_data;
          wr_d      = sel_wr;
          size_d    = sel_size;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = sel_wr ? S_WR_ADDR : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        if (bus.arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (bus.rvalid) state_d = S_IDLE;
      end
      S_WR_ADDR: begin
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        // Both channels may finish in the same cycle.
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (bus.bvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    bus.inst_addr_ok = 1'b0;
    bus.data_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.arvalid      = 1'b0;
    bus.rready       = 1'b0;
    bus.awvalid      = 1'b0;
    bus.wvalid       = 1'b0;
    bus.bready       = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.data_addr_ok = bus.data_req;
        bus.inst_addr_ok = bus.inst_req && !bus.data_req;
      end
      S_RD_ADDR: bus.arvalid = 1'b1;
      S_RD_DATA: begin
        bus.rready       = 1'b1;
        bus.data_data_ok = bus.rvalid && owner_q;
        bus.inst_data_ok = bus.rvalid && !owner_q;
      end
      S_WR_ADDR: begin
        bus.awvalid = !aw_done_q;
        bus.wvalid  = !w_done_q;
      end
      S_WR_RESP: begin
        bus.bready       = 1'b1;
        bus.data_data_ok = bus.bvalid && owner_q;
        bus.inst_data_ok = bus.bvalid && !owner_q;
      end
      default: ;
    endcase
  end

  // Byte-lane strobes from the latched size and low address bits.
  logic [3:0] strb;
  always_comb begin
    case (size_q)
      2'd0:    strb = 4'b0001 << addr_q[1:0];
      2'd1:    strb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  logic [3:0] cur_id;
  assign cur_id = owner_q ? DATA_ID : INST_ID;

  assign bus.arid    = cur_id;
  assign bus.araddr  = addr_q;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arburst = 2'b01;

  assign bus.awid    = cur_id;
  assign bus.awaddr  = addr_q;
  assign bus.awlen   = 8'd0;
  assign bus.awsize  = {1'b0, size_q};
  assign bus.awburst = 2'b01;

  // The core already replicates byte lanes, so write data goes out as latched.
  assign bus.wid     = cur_id;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = strb;
  assign bus.wlast   = 1'b1;

  // Read data is only meaningful to the owner while its data_ok is high.
  assign bus.inst_rdata = bus.rdata;
  assign bus.data_rdata = bus.rdata;

  // Response ids, status and rlast carry nothing the single-outstanding
  // scheme needs; they are intentionally ignored.
  logic unused_resp;
  assign unused_resp = ^{bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp, wr_q};

endmodule
